// File: rtl/serial_display_pkg.sv
// Shared constants and the Code-B segment lookup for the serial display receiver.
// Optional feature macro: SERIAL_RX_CODEB_EN (consumed by serial_display_receiver).
package serial_display_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCAN      = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam logic [7:0] RST_DIGIT     = 8'h00;
    localparam logic [7:0] RST_DECODE    = 8'h00;
    localparam logic [3:0] RST_INTENSITY = 4'h0;
    localparam logic [2:0] RST_SCAN      = 3'h0;
    localparam logic       RST_SHUTDOWN  = 1'b1;
    localparam logic       RST_TEST      = 1'b0;

    // Code-B decode: low nibble selects the glyph, bit 7 carries the decimal point.
    // Segment order is DP,A,B,C,D,E,F,G from bit 7 down to bit 0.
    function automatic logic [7:0] codeb_segments(input logic [7:0] stored);
        logic [6:0] seg;
        case (stored[3:0])
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h01;  // '-'
            4'hB:    seg = 7'h4F;  // 'E'
            4'hC:    seg = 7'h37;  // 'H'
            4'hD:    seg = 7'h0E;  // 'L'
            4'hE:    seg = 7'h67;  // 'P'
            default: seg = 7'h00;  // blank
        endcase
        return {stored[7], seg};
    endfunction

endpackage

// File: rtl/serial_input_sync.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
// level and rise are aligned: rise is high in the first cycle level reads 1.
module serial_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic                   rise_reg;

    // Synchroniser chain, edge-detect flop and registered rising-edge strobe.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
            edge_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~edge_reg;
        end
    end

    assign level = edge_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/serial_display_receiver.sv
// Receive end of the serial display link: decodes 16-bit frames into a
// MAX7219-style register file. Define SERIAL_RX_CODEB_EN to enable Code-B decode
// of digits whose decode-mode bit is set.
module serial_display_receiver
    import serial_display_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_serial_dout,
    input  logic        i_serial_load,
    input  logic        i_serial_clk,
    output logic [63:0] o_digits,
    output logic [7:0]  o_decode_mode,
    output logic [3:0]  o_intensity,
    output logic [2:0]  o_scan_limit,
    output logic        o_shutdown,
    output logic        o_test,
    output logic        o_frame_valid,
    output logic        o_frame_error
);

    logic dout_level, dout_rise_unused;
    logic clk_level_unused, clk_rise;
    logic load_level, load_rise;

    serial_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dout (
        .clk(i_clk), .srst(i_reset), .pin(i_serial_dout),
        .level(dout_level), .rise(dout_rise_unused)
    );
    serial_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(i_clk), .srst(i_reset), .pin(i_serial_clk),
        .level(clk_level_unused), .rise(clk_rise)
    );
    serial_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk(i_clk), .srst(i_reset), .pin(i_serial_load),
        .level(load_level), .rise(load_rise)
    );

    // Only address and data bits are kept; the top nibble of a frame is never used.
    logic [11:0] shift_reg, shift_next;
    logic [4:0]  count_reg, count_shift, count_next;
    logic        load_prev_reg;
    logic [7:0]  digit_reg [8];
    logic [7:0]  decode_reg;
    logic [3:0]  intensity_reg;
    logic [2:0]  scan_reg;
    logic        shutdown_reg, test_reg, valid_reg, error_reg;

    logic [3:0]  frame_addr;
    logic [7:0]  frame_data;
    logic        frame_full;
    logic [2:0]  digit_idx;

    // Shift a bit in (gated by the load level of the previous cycle), then
    // decide whether a commit in this same cycle sees a full frame.
    always_comb begin
        shift_next  = shift_reg;
        count_shift = count_reg;
        if (clk_rise && !load_prev_reg) begin
            shift_next = {shift_reg[10:0], dout_level};
            if (count_reg != 5'(FRAME_BITS)) begin
                count_shift = count_reg + 5'd1;
            end
        end
        count_next = load_rise ? 5'd0 : count_shift;
    end

    assign frame_full = (count_shift == 5'(FRAME_BITS));
    assign frame_addr = shift_next[11:8];
    assign frame_data = shift_next[7:0];
    assign digit_idx  = 3'(frame_addr - ADDR_DIGIT0);

    // Frame assembly, commit and register-file writes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_reg     <= '0;
            count_reg     <= '0;
            load_prev_reg <= 1'b0;
            for (int i = 0; i < 8; i++) digit_reg[i] <= RST_DIGIT;
            decode_reg    <= RST_DECODE;
            intensity_reg <= RST_INTENSITY;
            scan_reg      <= RST_SCAN;
            shutdown_reg  <= RST_SHUTDOWN;
            test_reg      <= RST_TEST;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            shift_reg     <= shift_next;
            count_reg     <= count_next;
            load_prev_reg <= load_level;
            valid_reg     <= 1'b0;
            error_reg     <= 1'b0;
            if (load_rise) begin
                if (frame_full) begin
                    valid_reg <= 1'b1;
                    if (frame_addr >= ADDR_DIGIT0 && frame_addr <= ADDR_DIGIT7) begin
                        digit_reg[digit_idx] <= frame_data;
                    end else begin
                        case (frame_addr)
                            ADDR_DECODE:    decode_reg    <= frame_data;
                            ADDR_INTENSITY: intensity_reg <= frame_data[3:0];
                            ADDR_SCAN:      scan_reg      <= frame_data[2:0];
                            ADDR_SHUTDOWN:  shutdown_reg  <= ~frame_data[0];
                            ADDR_TEST:      test_reg      <= frame_data[0];
                            default: ;  // no-op and unused addresses
                        endcase
                    end
                end else begin
                    error_reg <= 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
`ifdef SERIAL_RX_CODEB_EN
            assign o_digits[8*gi +: 8] = decode_reg[gi] ? codeb_segments(digit_reg[gi])
                                                        : digit_reg[gi];
`else
            assign o_digits[8*gi +: 8] = digit_reg[gi];
`endif
        end
    endgenerate

    assign o_decode_mode = decode_reg;
    assign o_intensity   = intensity_reg;
    assign o_scan_limit  = scan_reg;
    assign o_shutdown    = shutdown_reg;
    assign o_test        = test_reg;
    assign o_frame_valid = valid_reg;
    assign o_frame_error = error_reg;

endmodule

// File: tb/tb_serial_display_receiver.sv
// Directed bench for serial_display_receiver: drives serial frames on the pins
// and checks the register file and commit pulses against hand-computed values.
module tb_serial_display_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 2;
`ifdef SERIAL_RX_CODEB_EN
    localparam logic [7:0] EXP_CODEB_D0 = 8'hDB;
`else
    localparam logic [7:0] EXP_CODEB_D0 = 8'h85;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdout = 1'b0;
    logic        sload = 1'b0;
    logic        sclk = 1'b0;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown, test_flag, frame_valid, frame_error;

    int total = 0;
    int bad   = 0;

    serial_display_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_serial_dout(sdout), .i_serial_load(sload), .i_serial_clk(sclk),
        .o_digits(digits), .o_decode_mode(decode_mode), .o_intensity(intensity),
        .o_scan_limit(scan_limit), .o_shutdown(shutdown), .o_test(test_flag),
        .o_frame_valid(frame_valid), .o_frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sdout = b;
        tick(1);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    // Load has just been raised: watch a fixed window for commit pulses,
    // then drop load/clk and let the synchronisers settle.
    task automatic watch_commit(input string tag, input logic [31:0] v, input int n,
                                input int exp_valid, input int exp_error);
        int vcnt = 0, ecnt = 0, first = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (frame_valid) begin vcnt++; if (first == 0) first = i; end
            if (frame_error) begin ecnt++; if (first == 0) first = i; end
        end
        sload = 1'b0;
        sclk  = 1'b0;
        tick(6);
        $display("frame %s data=%0h bits=%0d valid=%0d error=%0d pulse_cycle=%0d",
                 tag, v, n, vcnt, ecnt, first);
        check({tag, " valid_count"}, 64'(vcnt), 64'(exp_valid));
        check({tag, " error_count"}, 64'(ecnt), 64'(exp_error));
        check({tag, " pulse_latency"}, 64'(first), 64'(LAT));
    endtask

    task automatic send_frame(input string tag, input logic [31:0] v, input int n,
                              input int exp_valid, input int exp_error);
        send_bits(v, n);
        sload = 1'b1;
        watch_commit(tag, v, n, exp_valid, exp_error);
    endtask

    initial begin
        int pulses;

        // Reset state
        tick(3);
        check("rst digits", digits, 64'h0);
        check("rst decode", 64'(decode_mode), 64'h0);
        check("rst intensity", 64'(intensity), 64'h0);
        check("rst scan", 64'(scan_limit), 64'h0);
        check("rst shutdown", 64'(shutdown), 64'h1);
        check("rst test", 64'(test_flag), 64'h0);
        check("rst pulses", 64'({frame_valid, frame_error}), 64'h0);
        rst = 1'b0;
        tick(2);

        // Digit write and shutdown release
        send_frame("digit2", 32'h0307, 16, 1, 0);
        check("digit2 digits", digits, 64'h0000_0000_0007_0000);
        send_frame("shutdown", 32'h0C01, 16, 1, 0);
        check("shutdown off", 64'(shutdown), 64'h0);

        // Short frame discarded, then a good intensity write
        send_frame("short", 32'h0105, 12, 0, 1);
        check("short digits kept", digits, 64'h0000_0000_0007_0000);
        check("short intensity kept", 64'(intensity), 64'h0);
        send_frame("intensity", 32'h0A0F, 16, 1, 0);
        check("intensity", 64'(intensity), 64'hF);

        // Long frame: last 16 bits are used
        send_frame("long", 32'hAB0155, 24, 1, 0);
        check("long digit0", digits, 64'h0000_0000_0007_0055);

        // Scan, test, ignored and no-op addresses
        send_frame("scan", 32'h0B05, 16, 1, 0);
        check("scan", 64'(scan_limit), 64'h5);
        send_frame("test", 32'h0F01, 16, 1, 0);
        check("test", 64'(test_flag), 64'h1);
        send_frame("addr_d", 32'h0D33, 16, 1, 0);
        send_frame("noop", 32'h0000, 16, 1, 0);
        check("ignored digits", digits, 64'h0000_0000_0007_0055);
        check("ignored regs", 64'({decode_mode, intensity, scan_limit, shutdown, test_flag}),
              64'({8'h00, 4'hF, 3'h5, 1'b0, 1'b1}));

        // Coincident last clk rise and load rise
        send_bits(32'h0466 >> 1, 15);
        sdout = 1'b0;
        tick(1);
        sclk  = 1'b1;
        sload = 1'b1;
        watch_commit("coincident", 32'h0466, 16, 1, 0);
        check("coincident digit3", digits, 64'h0000_0000_6607_0055);

        // Code-B decode of digit 0
        send_frame("decode", 32'h0901, 16, 1, 0);
        check("decode mode", 64'(decode_mode), 64'h01);
        send_frame("codeb", 32'h0185, 16, 1, 0);
        check("codeb digit0", 64'(digits[7:0]), 64'(EXP_CODEB_D0));

        // Reset mid-frame discards the partial frame silently
        send_bits(32'hA5, 8);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (frame_valid || frame_error) pulses++;
        end
        rst = 1'b0;
        tick(1);
        if (frame_valid || frame_error) pulses++;
        check("midreset pulses", 64'(pulses), 64'h0);
        check("midreset digits", digits, 64'h0);
        check("midreset shutdown", 64'(shutdown), 64'h1);
        send_frame("after_reset", 32'h0812, 16, 1, 0);
        check("after_reset digits", digits, 64'h1200_0000_0000_0000);
        check("after_reset intensity", 64'(intensity), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
